fft_frame_serializer: RTL and testbench

Frame-to-stream stage that accepts one complete 16-sample frame as a wide bus with a single-cycle `frame_valid` pulse and emits it one sample per cycle under a valid/ready handshake. The sample order is configurable: natural, or bit-reversed lane reordering that restores natural order from radix-2 FFT output. It holds up to two frames in a ping-pong store, so a new frame can land while the previous one is still draining. It sits directly after the 16-sample frame collector / FFT PE output and feeds the result writer.

---
 rtl/fft_pkg.sv | 24 ++
 rtl/fft_frame_serializer_slot.sv | 28 ++
 rtl/fft_frame_serializer.sv | 126 ++++++++++++
 tb/tb_fft_frame_serializer.sv | 241 ++++++++++++++++++++++++
 4 files changed

// File: rtl/fft_pkg.sv
// Shared FFT constants, occupancy encoding and the lane bit-reversal helper
// used by the frame serializer.
package fft_pkg;

    localparam int FFT_POINTS   = 16;
    localparam int SAMPLE_WIDTH = 32;
    localparam int IDX_WIDTH    = 4;

    typedef enum logic [1:0] {
        EMPTY = 2'd0,
        ONE   = 2'd1,
        FULL  = 2'd2
    } occ_t;

    function automatic logic [IDX_WIDTH-1:0] bitrev(input logic [IDX_WIDTH-1:0] v);
        logic [IDX_WIDTH-1:0] r;
        r = '0;
        for (int i = 0; i < IDX_WIDTH; i++) begin
            r[i] = v[IDX_WIDTH-1-i];
        end
        return r;
    endfunction

endpackage

// File: rtl/fft_frame_serializer_slot.sv
// One frame slot: a FRAME_LEN x DATA_WIDTH register bank loaded whole on a
// write-enable, with a lane select mux on the read side.
module frame_slot #(
    parameter int FRAME_LEN  = 16,
    parameter int DATA_WIDTH = 32
) (
    input  logic                            clk,
    input  logic                            rst,
    input  logic                            we,
    input  logic [FRAME_LEN*DATA_WIDTH-1:0] din,
    input  logic [$clog2(FRAME_LEN)-1:0]    rd_lane,
    output logic [DATA_WIDTH-1:0]           rd_data
);

    logic [FRAME_LEN*DATA_WIDTH-1:0] bank_r;

    // Whole-frame load; contents are cleared by reset.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            bank_r <= '0;
        end else if (we) begin
            bank_r <= din;
        end
    end

    assign rd_data = bank_r[rd_lane*DATA_WIDTH +: DATA_WIDTH];

endmodule

// File: rtl/fft_frame_serializer.sv
// Ping-pong frame store that serializes a 16-lane frame one sample per cycle,
// optionally in bit-reversed lane order to undo radix-2 FFT scrambling.
module fft_frame_serializer
    import fft_pkg::*;
#(
    parameter int FRAME_LEN   = FFT_POINTS,
    parameter int DATA_WIDTH  = SAMPLE_WIDTH,
    parameter int BIT_REVERSE = 1
) (
    input  logic                            clk,
    input  logic                            rst,
    input  logic                            frame_valid,
    input  logic [FRAME_LEN*DATA_WIDTH-1:0] frame_in,
    input  logic                            out_ready,
    output logic                            out_valid,
    output logic [DATA_WIDTH-1:0]           out_data,
    output logic [$clog2(FRAME_LEN)-1:0]    out_index,
    output logic                            out_last,
    output logic                            frame_drop,
    output logic                            busy
);

    localparam int IW = $clog2(FRAME_LEN);
    localparam logic [IW-1:0] LAST_SEQ = IW'(FRAME_LEN - 1);

    occ_t                  state_r;
    occ_t                  state_next;
    logic                  wr_sel_r;
    logic                  rd_sel_r;
    logic                  drop_r;
    logic [IW-1:0]         seq_r;
    logic [IW-1:0]         rd_lane;
    logic                  xfer;
    logic                  last_xfer;
    logic                  accept;
    logic                  drop;
    logic [DATA_WIDTH-1:0] rd0;
    logic [DATA_WIDTH-1:0] rd1;

    assign out_valid  = (state_r != EMPTY);
    assign busy       = out_valid;
    assign out_index  = seq_r;
    assign out_last   = out_valid && (seq_r == LAST_SEQ);
    assign out_data   = rd_sel_r ? rd1 : rd0;
    assign frame_drop = drop_r;

    assign xfer      = out_valid && out_ready;
    assign last_xfer = xfer && (seq_r == LAST_SEQ);
    // A slot freed by this cycle's last beat is reusable immediately; when full,
    // wr_sel already equals rd_sel so the write lands in the slot being freed.
    assign accept    = frame_valid && ((state_r != FULL) || last_xfer);
    assign drop      = frame_valid && (state_r == FULL) && !last_xfer;

    // Lane selection: natural or bit-reversed order.
    always_comb begin
        rd_lane = seq_r;
        if (BIT_REVERSE != 0) begin
            rd_lane = IW'(bitrev(IDX_WIDTH'(seq_r)));
        end else begin
            rd_lane = seq_r;
        end
    end

    // Occupancy next-state from accept and last-beat transfer.
    always_comb begin
        state_next = state_r;
        case (state_r)
            EMPTY: begin
                if (accept) state_next = ONE;
                else        state_next = EMPTY;
            end
            ONE: begin
                if (accept && !last_xfer)      state_next = FULL;
                else if (!accept && last_xfer) state_next = EMPTY;
                else                           state_next = ONE;
            end
            FULL: begin
                if (last_xfer && !accept) state_next = ONE;
                else                      state_next = FULL;
            end
            default: state_next = EMPTY;
        endcase
    end

    // Occupancy, pointers, sequence counter and drop pulse.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_r  <= EMPTY;
            wr_sel_r <= 1'b0;
            rd_sel_r <= 1'b0;
            seq_r    <= '0;
            drop_r   <= 1'b0;
        end else begin
            state_r <= state_next;
            drop_r  <= drop;
            if (accept) begin
                wr_sel_r <= ~wr_sel_r;
            end
            if (last_xfer) begin
                seq_r    <= '0;
                rd_sel_r <= ~rd_sel_r;
            end else if (xfer) begin
                seq_r <= seq_r + IW'(1);
            end
        end
    end

    frame_slot #(.FRAME_LEN(FRAME_LEN), .DATA_WIDTH(DATA_WIDTH)) u_slot0 (
        .clk     (clk),
        .rst     (rst),
        .we      (accept && !wr_sel_r),
        .din     (frame_in),
        .rd_lane (rd_lane),
        .rd_data (rd0)
    );

    frame_slot #(.FRAME_LEN(FRAME_LEN), .DATA_WIDTH(DATA_WIDTH)) u_slot1 (
        .clk     (clk),
        .rst     (rst),
        .we      (accept && wr_sel_r),
        .din     (frame_in),
        .rd_lane (rd_lane),
        .rd_data (rd1)
    );

endmodule

// File: tb/tb_fft_frame_serializer.sv
// Scoreboard bench driving a bit-reversed and a natural-order serializer with
// shared stimulus; expected beats are queued as frames are pulsed.
module tb_fft_frame_serializer;

    typedef struct packed {
        logic [31:0] d;
        logic [3:0]  i;
        logic        l;
    } beat_t;

    logic         clk = 1'b0;
    logic         rst = 1'b1;
    logic         frame_valid = 1'b0;
    logic [511:0] frame_in = '0;
    logic         out_ready = 1'b1;

    logic        br_valid, br_last, br_drop, br_busy;
    logic [31:0] br_data;
    logic [3:0]  br_index;
    logic        nt_valid, nt_last, nt_drop, nt_busy;
    logic [31:0] nt_data;
    logic [3:0]  nt_index;

    int n_checks = 0;
    int n_fail   = 0;

    beat_t q_br[$];
    beat_t q_nt[$];
    int    br_tab[16] = '{0, 8, 4, 12, 2, 10, 6, 14, 1, 9, 5, 13, 3, 11, 7, 15};

    logic  drop_pend = 1'b0;
    logic  drop_exp  = 1'b0;

    bit          br_stall, nt_stall;
    logic [36:0] br_hold, nt_hold;

    fft_frame_serializer #(.FRAME_LEN(16), .DATA_WIDTH(32), .BIT_REVERSE(1)) dut_br (
        .clk(clk), .rst(rst), .frame_valid(frame_valid), .frame_in(frame_in),
        .out_ready(out_ready), .out_valid(br_valid), .out_data(br_data),
        .out_index(br_index), .out_last(br_last), .frame_drop(br_drop), .busy(br_busy)
    );

    fft_frame_serializer #(.FRAME_LEN(16), .DATA_WIDTH(32), .BIT_REVERSE(0)) dut_nt (
        .clk(clk), .rst(rst), .frame_valid(frame_valid), .frame_in(frame_in),
        .out_ready(out_ready), .out_valid(nt_valid), .out_data(nt_data),
        .out_index(nt_index), .out_last(nt_last), .frame_drop(nt_drop), .busy(nt_busy)
    );

    always #5 clk = ~clk;

    task automatic check_value(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        n_checks++;
        if (obs !== exp) begin
            n_fail++;
            $display("FAIL %s: got 0x%0h, expected 0x%0h at %0t", tag, obs, exp, $time);
        end
    endtask

    function automatic logic [31:0] lane_val(input int tag, input int i);
        return {tag[11:0], i[3:0], tag[7:0], i[3:0], 4'h0};
    endfunction

    // Drive one frame in the current cycle and queue its expected beats.
    task automatic drive_frame(input int tag, input bit will_drop);
        frame_valid = 1'b1;
        drop_pend   = will_drop;
        for (int i = 0; i < 16; i++) frame_in[i*32 +: 32] = lane_val(tag, i);
        if (!will_drop) begin
            for (int k = 0; k < 16; k++) begin
                q_br.push_back('{lane_val(tag, br_tab[k]), 4'(k), (k == 15)});
                q_nt.push_back('{lane_val(tag, k), 4'(k), (k == 15)});
            end
        end
    endtask

    task automatic pulse(input int tag, input bit will_drop);
        @(posedge clk); #1;
        drive_frame(tag, will_drop);
        @(posedge clk); #1;
        frame_valid = 1'b0;
        drop_pend   = 1'b0;
    endtask

    task automatic wait_drain(input int max_cycles);
        for (int n = 0; n < max_cycles; n++) begin
            if (q_br.size() == 0 && q_nt.size() == 0) break;
            @(negedge clk);
        end
        check_value("drain_br", 64'(q_br.size()), 64'd0);
        check_value("drain_nt", 64'(q_nt.size()), 64'd0);
        @(negedge clk);
        check_value("idle_busy_br", br_busy, 1'b0);
        check_value("idle_busy_nt", nt_busy, 1'b0);
        check_value("idle_valid_br", br_valid, 1'b0);
    endtask

    task automatic check_reset_outputs();
        check_value("rst_valid_br", br_valid, 1'b0);
        check_value("rst_data_br", br_data, 32'h0);
        check_value("rst_index_br", br_index, 4'h0);
        check_value("rst_last_br", br_last, 1'b0);
        check_value("rst_drop_br", br_drop, 1'b0);
        check_value("rst_busy_br", br_busy, 1'b0);
        check_value("rst_valid_nt", nt_valid, 1'b0);
        check_value("rst_data_nt", nt_data, 32'h0);
        check_value("rst_busy_nt", nt_busy, 1'b0);
    endtask

    // Expected drop pulse appears the cycle after a rejected frame is sampled.
    always @(posedge clk or posedge rst) begin
        if (rst) drop_exp <= 1'b0;
        else     drop_exp <= frame_valid && drop_pend;
    end

    // Output monitor: scoreboard pops on transfers, stability while stalled.
    always @(negedge clk) begin
        if (rst) begin
            br_stall = 1'b0;
            nt_stall = 1'b0;
        end else begin
            check_value("drop_br", br_drop, drop_exp);
            check_value("drop_nt", nt_drop, drop_exp);
            if (br_stall) check_value("stall_br", {br_data, br_index, br_last}, br_hold);
            if (nt_stall) check_value("stall_nt", {nt_data, nt_index, nt_last}, nt_hold);
            br_stall = br_valid && !out_ready;
            nt_stall = nt_valid && !out_ready;
            br_hold  = {br_data, br_index, br_last};
            nt_hold  = {nt_data, nt_index, nt_last};
            if (br_valid && out_ready) begin
                if (q_br.size() == 0) check_value("sb_underflow_br", 1'b1, 1'b0);
                else check_value("beat_br", {br_data, br_index, br_last}, q_br.pop_front());
            end
            if (nt_valid && out_ready) begin
                if (q_nt.size() == 0) check_value("sb_underflow_nt", 1'b1, 1'b0);
                else check_value("beat_nt", {nt_data, nt_index, nt_last}, q_nt.pop_front());
            end
        end
    end

    initial begin
        #1;
        check_reset_outputs();
        @(posedge clk); #1;
        rst = 1'b0;

        // Single frame, natural data pattern, ready high.
        out_ready = 1'b1;
        pulse(0, 1'b0);
        check_value("latency_valid", br_valid, 1'b1);
        check_value("latency_index", br_index, 4'h0);
        wait_drain(100);

        // Random backpressure.
        out_ready = 1'b0;
        pulse(2, 1'b0);
        for (int n = 0; n < 400; n++) begin
            if (q_br.size() == 0 && q_nt.size() == 0) break;
            @(posedge clk); #1;
            out_ready = 1'($urandom_range(0, 1));
        end
        out_ready = 1'b1;
        wait_drain(100);

        // Two frames three cycles apart: 32 beats with no bubble.
        pulse(3, 1'b0);
        fork
            begin
                repeat (2) @(posedge clk);
                pulse(4, 1'b0);
            end
            begin
                for (int b = 0; b < 32; b++) begin
                    @(negedge clk);
                    check_value("no_bubble", br_valid, 1'b1);
                end
            end
        join
        wait_drain(100);

        // Third frame while full with backpressure is dropped.
        out_ready = 1'b0;
        pulse(5, 1'b0);
        pulse(6, 1'b0);
        pulse(7, 1'b1);
        @(negedge clk);
        check_value("full_busy", br_busy, 1'b1);
        @(posedge clk); #1;
        out_ready = 1'b1;
        wait_drain(200);

        // Third frame arrives exactly on frame A's last transfer.
        pulse(8, 1'b0);
        pulse(9, 1'b0);
        begin : find_last
            bit seen;
            seen = 1'b0;
            for (int n = 0; n < 60; n++) begin
                @(negedge clk); #1;
                if (br_last && out_ready) begin
                    seen = 1'b1;
                    break;
                end
            end
            check_value("last_seen", seen, 1'b1);
        end
        drive_frame(10, 1'b0);
        @(posedge clk); #1;
        frame_valid = 1'b0;
        wait_drain(200);

        // Reset mid-frame at beat 7.
        pulse(11, 1'b0);
        begin : find_beat7
            bit seen;
            seen = 1'b0;
            for (int n = 0; n < 40; n++) begin
                @(negedge clk); #1;
                if (br_index == 4'd7) begin
                    seen = 1'b1;
                    break;
                end
            end
            check_value("beat7_seen", seen, 1'b1);
        end
        @(posedge clk); #1;
        rst = 1'b1;
        #1;
        check_reset_outputs();
        q_br.delete();
        q_nt.delete();
        @(posedge clk); #1;
        rst = 1'b0;
        pulse(12, 1'b0);
        check_value("post_rst_index", br_index, 4'h0);
        wait_drain(100);

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
